dcache_responder: RTL and testbench
===================================

// Module: dcache_responder
// PURPOSE
// Data-cache responder for the pipeline's memory-stage word port. Serves word reads and
// byte-enabled writes from a direct-mapped, write-back, write-allocate array of 32-byte lines.
// Misses are handled by a 3-state FSM against a 256-bit line-granular physical-memory port.
// Sits between the memory stage and the memory arbiter/bus adapter.
// PARAMETERS
// S_INDEX  3  index bits; number of sets = 2**S_INDEX; tag = addr[31:5+S_INDEX]
// PORTS
// clk               in   1    clock; all state updates on rising edge
// rst               in   1    reset: asynchronous, active-low
// mem_read          in   1    word read request; held stable until mem_resp
// mem_write         in   1    write request; held stable until mem_resp
// mem_byte_enable   in   4    write byte lanes; bit i -> wdata[8i+7:8i]; ignored on reads
// mem_address       in   32   byte address; [1:0] ignored (requester aligns)
// mem_wdata         in   32   write data, already lane-aligned by requester
// mem_rdata         out  32   full read word, registered; valid while mem_resp=1
// mem_resp          out  1    one-cycle completion pulse
// pmem_read         out  1    line fill request; held until pmem_resp
// pmem_write        out  1    line writeback request; held until pmem_resp
// pmem_address      out  32   line address, [4:0]=0
// pmem_wdata        out  256  victim line; word w at [32w+31:32w]
// pmem_rdata        in   256  fill line, valid when pmem_resp=1
// pmem_resp         in   1    one-cycle completion of pmem_read/pmem_write
// BEHAVIOUR
// - Reset (rst low, async): state=IDLE; all valid/dirty bits=0; mem_resp=0; mem_rdata=0;
//   pmem_read=pmem_write=0; pmem_address=0; pmem_wdata=0. Tag/data arrays are not reset.
// - States: IDLE, RESP, WRITEBACK, ALLOCATE. Flop arrays; hit = valid[idx] & tag match.
// - IDLE, no request: all outputs idle.
// - IDLE, request and hit:
//   - read: latch word addr[4:2] into mem_rdata.
//   - write: update enabled bytes only; set dirty iff byte_enable != 0.
//   - Next state RESP.
// - IDLE, request and miss: dirty victim -> WRITEBACK, else -> ALLOCATE.
// - Both mem_read and mem_write high is illegal; treat as write.
// - RESP: mem_resp=1 for exactly one cycle; requests are not sampled; next state IDLE.
//   Hit latency: mem_resp in the 2nd cycle after the request is first seen.
// - WRITEBACK: pmem_write=1; pmem_address={victim_tag, idx, 5'b0}; pmem_wdata=victim line.
//   All held stable until pmem_resp, then -> ALLOCATE.
// - ALLOCATE: pmem_read=1; pmem_address={mem_address[31:5], 5'b0}.
//   On pmem_resp: write line, set tag, valid=1, dirty=0; -> IDLE. The request then re-evaluates as a hit.
// - pmem_wdata=0 whenever pmem_write=0; pmem_address=0 when neither pmem strobe is high.
// - pmem_resp outside WRITEBACK/ALLOCATE is ignored. pmem stalls of any length are legal.
// - Reset mid-operation aborts any pmem transaction immediately.
//   The line being filled stays invalid; no partial line is ever marked valid.
// TESTING (S_INDEX=3)
// 1 Reset, read 0x0000_1004 -> pmem_read @0x0000_1000; return line with word1=0xDEADBEEF
//   -> mem_resp once with rdata 0xDEADBEEF. Repeat read -> no pmem traffic, resp on cycle 2.
// 2 Write 0x0000_1004, be=4'b0100, wdata=0x00AB0000 -> resp.
//   Read 0x0000_1004 -> 0xDEABBEEF. Line now dirty.
// 3 Read 0x0000_2004 (same set, new tag) -> pmem_write @0x0000_1000, wdata word1=0xDEABBEEF;
//   then pmem_read @0x0000_2000; then mem_resp with the fill word1.
// 4 Delay pmem_resp 10 cycles in WRITEBACK and in ALLOCATE -> strobes, address and wdata
//   stable throughout; mem_resp stays 0.
// 5 Drive rst low mid-ALLOCATE -> all outputs 0 immediately.
//   After release, read same address -> miss again; no writeback.
// 6 Hit write with be=4'b0000 -> resp, data unchanged.
//   Conflicting read -> no pmem_write, only pmem_read.

Source files
------------

// File: rtl/dcache_responder_if.sv
// Memory-stage word port and line-granular physical-memory port of the data cache.
// The slave modport is the cache's view; master is the requester/memory side.
interface dcache_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;

  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache of 32-byte lines serving word
// reads and byte-enabled writes; misses go through writeback/allocate on the line port.
module dcache_responder #(
  parameter int unsigned S_INDEX = 3
) (
  input  logic               clk,
  input  logic               rst,
  dcache_responder_if.slave  bus
);

  localparam int unsigned NSETS  = 1 << S_INDEX;
  localparam int unsigned TAG_W  = 32 - 5 - S_INDEX;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [LINE_W-1:0] data_q [NSETS];
  logic [TAG_W-1:0]  tag_q  [NSETS];
  logic [NSETS-1:0]  valid_q;
  logic [NSETS-1:0]  dirty_q;

  logic              mem_resp_q, mem_resp_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [31:0]       pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

  logic [S_INDEX-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [2:0]         word;
  logic               req;
  logic               is_write;
  logic               hit;
  logic               victim_dirty;
  logic [LINE_W-1:0]  cur_line;
  logic [LINE_W-1:0]  wr_line;
  logic [31:0]        cur_word;
  logic [7:0]         lane_lsb;
  logic               fill_we;
  logic               hit_we;
  logic               dirty_set;
  logic [1:0]         unused_addr_bits;

  assign idx              = bus.mem_address[5 +: S_INDEX];
  assign tag              = bus.mem_address[31 -: TAG_W];
  assign word             = bus.mem_address[4:2];
  assign unused_addr_bits = bus.mem_address[1:0];
  assign req              = bus.mem_read | bus.mem_write;
  assign is_write         = bus.mem_write;
  assign cur_line         = data_q[idx];
  assign cur_word         = cur_line[{word, 5'd0} +: 32];
  assign hit              = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty     = valid_q[idx] && dirty_q[idx];

  // Merge the enabled write lanes into the addressed line.
  always_comb begin
    wr_line  = cur_line;
    lane_lsb = '0;
    for (int b = 0; b < 4; b++) begin
      lane_lsb = {word, 2'(b), 3'd0};
      if (bus.mem_byte_enable[b]) begin
        wr_line[lane_lsb +: 8] = bus.mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, array write enables and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    mem_rdata_d = mem_rdata_q;
    fill_we     = 1'b0;
    hit_we      = 1'b0;
    dirty_set   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (is_write) begin
              hit_we    = 1'b1;
              dirty_set = |bus.mem_byte_enable;
            end else begin
              mem_rdata_d = cur_word;
            end
            state_d = RESP;
          end else if (victim_dirty) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      WRITEBACK: begin
        if (bus.pmem_resp) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (bus.pmem_resp) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the state being entered so they line up with it.
    mem_resp_d     = (state_d == RESP);
    pmem_write_d   = (state_d == WRITEBACK);
    pmem_read_d    = (state_d == ALLOCATE);
    pmem_wdata_d   = '0;
    pmem_address_d = '0;
    if (state_d == WRITEBACK) begin
      pmem_wdata_d   = cur_line;
      pmem_address_d = {tag_q[idx], idx, 5'd0};
    end else if (state_d == ALLOCATE) begin
      pmem_address_d = {bus.mem_address[31:5], 5'd0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  // Line state bits; a fill aborted by reset never reaches the valid update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (hit_we && dirty_set) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[idx] <= bus.pmem_rdata;
      tag_q[idx]  <= tag;
    end else if (hit_we) begin
      data_q[idx] <= wr_line;
    end
  end

  assign bus.mem_resp     = mem_resp_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: hand-computed vectors against a small line memory.
`timescale 1ns/1ps
module tb_dcache_responder;

  logic clk;
  logic rst;
  dcache_responder_if bus ();

  dcache_responder #(.S_INDEX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] pmem [logic [26:0]];

  int           n_wb, n_fill, wb_cyc, fill_cyc, resp_cnt, resp_cyc, stable_err;
  int           idle_err = 0;
  logic [31:0]  wb_addr, fill_addr, rdata_seen;
  logic [255:0] wb_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Unwritten lines hold word w = line address + w.
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (pmem.exists(a[31:5])) return pmem[a[31:5]];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = {a[31:5], 5'd0} + 32'(w);
    return l;
  endfunction

  // One request from a negedge until mem_resp plus two idle cycles; dly = pmem stall cycles.
  // abort_fill > 0 drops reset after that many ALLOCATE cycles.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int dly, input int abort_fill);
    int  cyc, tail, wb_run, fill_run;
    bit  done, aborted, prev_w, prev_r;
    n_wb = 0; n_fill = 0; wb_cyc = 0; fill_cyc = 0; resp_cnt = 0; resp_cyc = 0;
    stable_err = 0; rdata_seen = '0; wb_addr = '0; fill_addr = '0; wb_data = '0;
    cyc = 0; tail = 0; wb_run = 0; fill_run = 0;
    done = 0; aborted = 0; prev_w = 0; prev_r = 0;
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = addr;
    bus.mem_byte_enable = be; bus.mem_wdata = wd;
    while (!(done && tail >= 2) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.pmem_resp = 1'b0;
      if (done) tail++;
      if (bus.mem_resp) begin
        resp_cnt++;
        if (!done) begin
          rdata_seen = bus.mem_rdata; resp_cyc = cyc + 1; done = 1;
          bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        end
      end
      if (!bus.pmem_write && bus.pmem_wdata != '0) idle_err++;
      if (!bus.pmem_write && !bus.pmem_read && bus.pmem_address != '0) idle_err++;
      if (bus.pmem_write && bus.pmem_read) idle_err++;
      if (bus.pmem_write) begin
        if (!prev_w) begin
          n_wb++; wb_addr = bus.pmem_address; wb_data = bus.pmem_wdata; wb_run = 0;
        end else if (bus.pmem_address != wb_addr || bus.pmem_wdata != wb_data || bus.mem_resp) begin
          stable_err++;
        end
        wb_run++; wb_cyc++;
        if (wb_run == dly + 1) begin
          pmem[wb_addr[31:5]] = wb_data;
          bus.pmem_resp = 1'b1;
        end
      end
      if (bus.pmem_read) begin
        if (!prev_r) begin
          n_fill++; fill_addr = bus.pmem_address; fill_run = 0;
        end else if (bus.pmem_address != fill_addr || bus.mem_resp) begin
          stable_err++;
        end
        fill_run++; fill_cyc++;
        if (abort_fill > 0 && fill_run == abort_fill) begin
          #2 rst = 1'b0;
          #1;
          chk("rst_mem_resp",   32'(bus.mem_resp), 32'd0);
          chk("rst_mem_rdata",  bus.mem_rdata, 32'd0);
          chk("rst_pmem_read",  32'(bus.pmem_read), 32'd0);
          chk("rst_pmem_write", 32'(bus.pmem_write), 32'd0);
          chk("rst_pmem_addr",  bus.pmem_address, 32'd0);
          chk("rst_pmem_wdata", 32'(|bus.pmem_wdata), 32'd0);
          bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
          @(negedge clk);
          rst = 1'b1;
          aborted = 1;
          break;
        end else if (abort_fill == 0 && fill_run == dly + 1) begin
          bus.pmem_rdata = line_of(fill_addr);
          bus.pmem_resp  = 1'b1;
        end
      end
      prev_w = bus.pmem_write;
      prev_r = bus.pmem_read;
    end
    bus.pmem_resp = 1'b0;
    if (!aborted) chk("resp_once", resp_cnt, 1);
  endtask

  initial begin
    rst = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = '0;
    bus.mem_address = '0; bus.mem_wdata = '0; bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    pmem[27'h0000080] = {32'h00001007, 32'h00001006, 32'h00001005, 32'h00001004,
                         32'h00001003, 32'h00001002, 32'hDEADBEEF, 32'h00001000};
    repeat (2) @(negedge clk);
    chk("reset_mem_resp",   32'(bus.mem_resp), 32'd0);
    chk("reset_mem_rdata",  bus.mem_rdata, 32'd0);
    chk("reset_pmem_read",  32'(bus.pmem_read), 32'd0);
    chk("reset_pmem_write", 32'(bus.pmem_write), 32'd0);
    chk("reset_pmem_addr",  bus.pmem_address, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss, then hit.
    access(1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, 0);
    chk("t1_nfill", n_fill, 1);
    chk("t1_nwb", n_wb, 0);
    chk("t1_fill_addr", fill_addr, 32'h0000_1000);
    chk("t1_rdata", rdata_seen, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, 0);
    chk("t1_hit_nfill", n_fill, 0);
    chk("t1_hit_lat", resp_cyc, 2);
    chk("t1_hit_rdata", rdata_seen, 32'hDEADBEEF);

    // Single-lane write hit.
    access(1'b0, 1'b1, 32'h0000_1004, 4'b0100, 32'h00AB_0000, 0, 0);
    chk("t2_wr_lat", resp_cyc, 2);
    chk("t2_wr_nfill", n_fill, 0);
    access(1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, 0);
    chk("t2_rdata", rdata_seen, 32'hDEABBEEF);

    // Dirty conflict: writeback then fill.
    access(1'b1, 1'b0, 32'h0000_2004, 4'h0, 32'h0, 0, 0);
    chk("t3_nwb", n_wb, 1);
    chk("t3_wb_addr", wb_addr, 32'h0000_1000);
    chk("t3_wb_w1", wb_data[63:32], 32'hDEABBEEF);
    chk("t3_wb_w0", wb_data[31:0], 32'h0000_1000);
    chk("t3_nfill", n_fill, 1);
    chk("t3_fill_addr", fill_addr, 32'h0000_2000);
    chk("t3_rdata", rdata_seen, 32'h0000_2001);

    // Stalled writeback and fill.
    access(1'b0, 1'b1, 32'h0000_2008, 4'hF, 32'h1234_5678, 0, 0);
    access(1'b1, 1'b0, 32'h0000_1008, 4'h0, 32'h0, 10, 0);
    chk("t4_wb_addr", wb_addr, 32'h0000_2000);
    chk("t4_wb_w2", wb_data[95:64], 32'h1234_5678);
    chk("t4_wb_cyc", wb_cyc, 11);
    chk("t4_fill_cyc", fill_cyc, 11);
    chk("t4_stable", stable_err, 0);
    chk("t4_fill_addr", fill_addr, 32'h0000_1000);
    chk("t4_rdata", rdata_seen, 32'h0000_1002);
    access(1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, 0);
    chk("t4_roundtrip", rdata_seen, 32'hDEABBEEF);

    // Reset during allocate, set 1.
    access(1'b1, 1'b0, 32'h0000_1024, 4'h0, 32'h0, 0, 0);
    chk("t5_pre_rdata", rdata_seen, 32'h0000_1021);
    access(1'b0, 1'b1, 32'h0000_1024, 4'hF, 32'hCAFE_F00D, 0, 0);
    access(1'b1, 1'b0, 32'h0000_2024, 4'h0, 32'h0, 0, 3);
    chk("t5_wb_addr", wb_addr, 32'h0000_1020);
    chk("t5_wb_w1", wb_data[63:32], 32'hCAFE_F00D);
    access(1'b1, 1'b0, 32'h0000_2024, 4'h0, 32'h0, 0, 0);
    chk("t5_post_nwb", n_wb, 0);
    chk("t5_post_nfill", n_fill, 1);
    chk("t5_post_fill_addr", fill_addr, 32'h0000_2020);
    chk("t5_post_rdata", rdata_seen, 32'h0000_2021);

    // Zero byte-enable write leaves line clean.
    access(1'b0, 1'b1, 32'h0000_2024, 4'h0, 32'hFFFF_FFFF, 0, 0);
    chk("t6_wr_lat", resp_cyc, 2);
    access(1'b1, 1'b0, 32'h0000_2024, 4'h0, 32'h0, 0, 0);
    chk("t6_rdata", rdata_seen, 32'h0000_2021);
    access(1'b1, 1'b0, 32'h0000_3024, 4'h0, 32'h0, 0, 0);
    chk("t6_nwb", n_wb, 0);
    chk("t6_nfill", n_fill, 1);
    chk("t6_fill_addr", fill_addr, 32'h0000_3020);
    chk("t6_rdata_miss", rdata_seen, 32'h0000_3021);

    // Read and write together act as a write.
    access(1'b1, 1'b1, 32'h0000_3028, 4'hF, 32'h55AA_55AA, 0, 0);
    access(1'b1, 1'b0, 32'h0000_3028, 4'h0, 32'h0, 0, 0);
    chk("t7_rw_as_write", rdata_seen, 32'h55AA_55AA);

    chk("idle_outputs", idle_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
